// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared word and block definitions for the AES datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

   localparam int WORD_W  = 32;
   localparam int BLOCK_W = 128;

   typedef logic [WORD_W-1:0] word_t;

endpackage : aes_pkg
`default_nettype wire

// File: rtl/col_loader.sv
`default_nettype none
// ============================================================================
//  Module      : col_loader
//  Description : Assembles a stream of 32-bit words into blocks of COL_NUM
//                columns. A fill register collects the current block while a
//                hold register presents the previous one, so a continuous
//                input stream runs at one word per cycle.
//                Note: in_ready depends combinationally on out_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module col_loader
   import aes_pkg::*;
#(
   parameter int  SIZE    = BLOCK_W,
   localparam int COL_NUM = SIZE / WORD_W
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  flush,
   input  logic  in_valid,
   output logic  in_ready,
   input  word_t in_word,
   output word_t cols [0:COL_NUM-1],
   output logic  out_valid,
   input  logic  out_ready,
   output logic  busy
);

   localparam int               CNT_W    = (COL_NUM > 1) ? $clog2(COL_NUM) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(COL_NUM - 1);

   typedef word_t col_arr_t [0:COL_NUM-1];

   logic [CNT_W-1:0] cnt_q, cnt_d;
   col_arr_t         fill_q, fill_d;
   col_arr_t         hold_q, hold_d;
   logic             out_valid_q, out_valid_d;

   logic hold_free;
   logic at_last;
   logic accept;

   // The last slot may only be written when the hold register can take the block.
   always_comb begin
      hold_free = !out_valid_q || out_ready;
      at_last   = (cnt_q == LAST_IDX);
      in_ready  = !flush && (!at_last || hold_free);
      accept    = in_valid && in_ready;
   end

   // Next state: fill a slot, or move the completed block into hold.
   always_comb begin
      cnt_d       = cnt_q;
      fill_d      = fill_q;
      hold_d      = hold_q;
      // A consumed block drops out_valid unless a new block replaces it below.
      out_valid_d = out_valid_q && !out_ready;
      if (flush) begin
         cnt_d = '0;
      end else if (accept) begin
         if (at_last) begin
            hold_d              = fill_q;
            hold_d[COL_NUM-1]   = in_word;
            out_valid_d         = 1'b1;
            cnt_d               = '0;
         end else begin
            fill_d[cnt_q] = in_word;
            cnt_d         = cnt_q + CNT_W'(1);
         end
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q       <= '0;
         fill_q      <= '{default: '0};
         hold_q      <= '{default: '0};
         out_valid_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         fill_q      <= fill_d;
         hold_q      <= hold_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign cols      = hold_q;
   assign out_valid = out_valid_q;
   assign busy      = (cnt_q != '0);

endmodule : col_loader
`default_nettype wire
